// File: rtl/abs_pkg.sv
// Shared types and constants for the abs_arb scheduler and its cal_abs magnitude pipeline.
package abs_pkg;

    localparam int unsigned AbsDefDw  = 8;
    localparam int unsigned AbsDefLat = 4;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // Channel index width; never zero so a single-bit tag exists even for tiny configs.
    function automatic int unsigned chw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/abs_tag_pipe.sv
// Tracks {valid, channel} tags alongside cal_abs and labels each returned magnitude.
module abs_tag_pipe import abs_pkg::*; #(
    parameter int unsigned CHW     = 2,
    parameter int unsigned DW      = AbsDefDw,
    parameter int unsigned ABS_LAT = AbsDefLat
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tag_val_i,
    input  logic [CHW-1:0] tag_ch_i,
    input  logic           abs_val_i,
    input  logic [DW-1:0]  abs_i,
    output logic           res_val_o,
    output logic [DW-1:0]  res_abs_o,
    output logic [CHW-1:0] res_ch_o,
    output logic           err_o,
    output logic           busy_o
);

    logic [ABS_LAT-1:0] vld_q;
    logic [CHW-1:0]     ch_q [ABS_LAT];
    logic               res_val_q;
    logic [DW-1:0]      res_abs_q;
    logic [CHW-1:0]     res_ch_q;
    logic               err_q;
    logic               out_vld;
    logic [CHW-1:0]     out_ch;

    assign out_vld = vld_q[ABS_LAT-1];
    assign out_ch  = ch_q[ABS_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < ABS_LAT; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= tag_val_i;
            ch_q[0]  <= tag_ch_i;
            for (int i = 1; i < ABS_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                ch_q[i]  <= ch_q[i-1];
            end
        end
    end

    // An untagged abs_val_i (stale cal_abs contents) is dropped without flagging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_val_q <= 1'b0;
            res_abs_q <= '0;
            res_ch_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            res_val_q <= out_vld & abs_val_i;
            if (out_vld && abs_val_i) begin
                res_abs_q <= abs_i;
                res_ch_q  <= out_ch;
            end
            if (out_vld && !abs_val_i) begin
                err_q <= 1'b1;
            end
        end
    end

    assign res_val_o = res_val_q;
    assign res_abs_o = res_abs_q;
    assign res_ch_o  = res_ch_q;
    assign err_o     = err_q;
    assign busy_o    = |vld_q;

endmodule

// File: rtl/abs_arb.sv
// Round-robin burst scheduler sharing one cal_abs pipeline among NUM_CH requesters.
// Define ABS_ARB_STATS_EN to build per-channel delivered-result counters.
module abs_arb import abs_pkg::*; #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DW        = AbsDefDw,
    parameter int unsigned ABS_LAT   = AbsDefLat,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_val_i,
    input  logic [NUM_CH*DW-1:0]     req_real_i,
    input  logic [NUM_CH*DW-1:0]     req_imag_i,
    output logic [NUM_CH-1:0]        req_rdy_o,
    output logic                     abs_val_o,
    output logic [DW-1:0]            abs_real_o,
    output logic [DW-1:0]            abs_imag_o,
    input  logic                     abs_val_i,
    input  logic [DW-1:0]            abs_i,
    output logic                     res_val_o,
    output logic [DW-1:0]            res_abs_o,
    output logic [chw(NUM_CH)-1:0]   res_ch_o,
    output logic                     busy_o,
    output logic                     err_o,
    input  logic [chw(NUM_CH)-1:0]   stat_sel_i,
    output logic [15:0]              stat_cnt_o
);

    localparam int unsigned CHW = chw(NUM_CH);
    localparam int unsigned BCW = $clog2(BURST_LEN + 1);

    arb_state_e     state_q;
    logic [CHW-1:0] gnt_ch_q;
    logic [CHW-1:0] rr_ptr_q;
    logic [CHW-1:0] iss_ch_q;
    logic [BCW-1:0] burst_cnt_q;
    logic           abs_val_q;
    logic [DW-1:0]  abs_real_q;
    logic [DW-1:0]  abs_imag_q;

    logic           found;
    logic [CHW-1:0] pick_ch;
    logic [CHW-1:0] next_ptr;
    logic           gnt_val;
    logic           tag_busy;

    // First requester at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        pick_ch = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && req_val_i[idx]) begin
                found   = 1'b1;
                pick_ch = CHW'(idx);
            end
        end
    end

    assign next_ptr  = (32'(gnt_ch_q) == NUM_CH - 1) ? '0 : gnt_ch_q + CHW'(1);
    assign gnt_val   = req_val_i[gnt_ch_q];
    assign req_rdy_o = (state_q == StGrant) ? (NUM_CH'(1) << gnt_ch_q) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_ch_q    <= '0;
            rr_ptr_q    <= '0;
            iss_ch_q    <= '0;
            burst_cnt_q <= '0;
            abs_val_q   <= 1'b0;
            abs_real_q  <= '0;
            abs_imag_q  <= '0;
        end else begin
            abs_val_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        gnt_ch_q <= pick_ch;
                        state_q  <= StGrant;
                    end
                end
                StGrant: begin
                    if (!gnt_val) begin
                        // Requester dropped valid: release without a transfer.
                        rr_ptr_q    <= next_ptr;
                        burst_cnt_q <= '0;
                        state_q     <= StIdle;
                    end else begin
                        abs_val_q  <= 1'b1;
                        abs_real_q <= req_real_i[32'(gnt_ch_q)*DW +: DW];
                        abs_imag_q <= req_imag_i[32'(gnt_ch_q)*DW +: DW];
                        iss_ch_q   <= gnt_ch_q;
                        if (burst_cnt_q == BCW'(BURST_LEN - 1)) begin
                            rr_ptr_q    <= next_ptr;
                            burst_cnt_q <= '0;
                            state_q     <= StIdle;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + BCW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign abs_val_o  = abs_val_q;
    assign abs_real_o = abs_real_q;
    assign abs_imag_o = abs_imag_q;

    // Fed from the issue register so the last stage lines up with cal_abs val_o.
    abs_tag_pipe #(
        .CHW     (CHW),
        .DW      (DW),
        .ABS_LAT (ABS_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_val_i (abs_val_q),
        .tag_ch_i  (iss_ch_q),
        .abs_val_i (abs_val_i),
        .abs_i     (abs_i),
        .res_val_o (res_val_o),
        .res_abs_o (res_abs_o),
        .res_ch_o  (res_ch_o),
        .err_o     (err_o),
        .busy_o    (tag_busy)
    );

    assign busy_o = (state_q == StGrant) | abs_val_q | tag_busy;

`ifdef ABS_ARB_STATS_EN
    logic [15:0] stat_q [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_q[i] <= '0;
            end
        end else if (res_val_o) begin
            stat_q[res_ch_o] <= stat_q[res_ch_o] + 16'd1;
        end
    end

    assign stat_cnt_o = (32'(stat_sel_i) < NUM_CH) ? stat_q[stat_sel_i] : '0;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel_i;
    assign stat_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_abs_arb.sv
// Directed bench for abs_arb with a behavioural cal_abs stand-in (exact integer magnitude).
module tb_abs_arb;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned DW        = 8;
    localparam int unsigned ABS_LAT   = 4;
    localparam int unsigned BURST_LEN = 16;
    localparam int unsigned CHW       = 2;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    req_val_i;
    logic [NUM_CH*DW-1:0] req_real_i;
    logic [NUM_CH*DW-1:0] req_imag_i;
    logic [NUM_CH-1:0]    req_rdy_o;
    logic                 abs_val_o;
    logic [DW-1:0]        abs_real_o;
    logic [DW-1:0]        abs_imag_o;
    logic                 abs_val_i;
    logic [DW-1:0]        abs_i;
    logic                 res_val_o;
    logic [DW-1:0]        res_abs_o;
    logic [CHW-1:0]       res_ch_o;
    logic                 busy_o;
    logic                 err_o;
    logic [CHW-1:0]       stat_sel_i;
    logic [15:0]          stat_cnt_o;

    abs_arb #(
        .NUM_CH    (NUM_CH),
        .DW        (DW),
        .ABS_LAT   (ABS_LAT),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val_i  (req_val_i),
        .req_real_i (req_real_i),
        .req_imag_i (req_imag_i),
        .req_rdy_o  (req_rdy_o),
        .abs_val_o  (abs_val_o),
        .abs_real_o (abs_real_o),
        .abs_imag_o (abs_imag_o),
        .abs_val_i  (abs_val_i),
        .abs_i      (abs_i),
        .res_val_o  (res_val_o),
        .res_abs_o  (res_abs_o),
        .res_ch_o   (res_ch_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .stat_sel_i (stat_sel_i),
        .stat_cnt_o (stat_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] isqrt(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int s;
        int r;
        s = int'(re) * int'(re) + int'(im) * int'(im);
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return DW'(r);
    endfunction

    // cal_abs stand-in: no reset, fixed latency.
    logic          mdl_v [ABS_LAT];
    logic [DW-1:0] mdl_m [ABS_LAT];
    logic          kill;
    bit            kill_arm;

    always @(posedge clk) begin
        mdl_v[0] <= abs_val_o;
        mdl_m[0] <= isqrt(abs_real_o, abs_imag_o);
        for (int i = 1; i < ABS_LAT; i++) begin
            mdl_v[i] <= mdl_v[i-1];
            mdl_m[i] <= mdl_m[i-1];
        end
    end

    assign abs_val_i = mdl_v[ABS_LAT-1] & ~kill;
    assign abs_i     = mdl_m[ABS_LAT-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int            src_cnt [NUM_CH];
    logic [DW-1:0] pay_re [NUM_CH];
    logic [DW-1:0] pay_im [NUM_CH];

    int xfer_log [$];
    int res_ch [$];
    int res_abs [$];
    int run_ch [$];
    int run_x [$];
    int run_len [$];
    int run_gap [$];
    bit in_run;
    int cur_ch, cur_len, cur_x, cur_gap, last_end;
    int xfer_first, res_first, onehot_bad;

    task automatic clear_logs();
        xfer_log.delete(); res_ch.delete(); res_abs.delete();
        run_ch.delete(); run_x.delete(); run_len.delete(); run_gap.delete();
        in_run = 0; last_end = cyc; xfer_first = -1; res_first = -1; onehot_bad = 0;
    endtask

    task automatic close_run();
        run_ch.push_back(cur_ch);
        run_x.push_back(cur_x);
        run_len.push_back(cur_len);
        run_gap.push_back(cur_gap);
        in_run = 0;
        last_end = cyc - 1;
    endtask

    task automatic sample();
        int rch;
        rch = 0;
        if ($countones(req_rdy_o) > 1) onehot_bad++;
        for (int k = 0; k < NUM_CH; k++) begin
            if (req_rdy_o[k]) rch = k;
            if (req_val_i[k] && req_rdy_o[k]) begin
                xfer_log.push_back(k);
                if (src_cnt[k] > 0) src_cnt[k]--;
                if (xfer_first < 0) xfer_first = cyc;
            end
        end
        if (req_rdy_o != '0) begin
            if (in_run && rch != cur_ch) close_run();
            if (!in_run) begin
                in_run = 1; cur_ch = rch; cur_len = 0; cur_x = 0;
                cur_gap = cyc - last_end - 1;
            end
            cur_len++;
            if (req_val_i[rch]) cur_x++;
        end else if (in_run) begin
            close_run();
        end
        if (res_val_o) begin
            res_ch.push_back(int'(res_ch_o));
            res_abs.push_back(int'(res_abs_o));
            if (res_first < 0) res_first = cyc;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NUM_CH; k++) begin
            req_val_i[k]             = (src_cnt[k] > 0);
            req_real_i[k*DW +: DW]   = pay_re[k];
            req_imag_i[k*DW +: DW]   = pay_im[k];
        end
        if (kill_arm && mdl_v[ABS_LAT-1]) begin
            kill = 1'b1;
            kill_arm = 0;
        end else begin
            kill = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_idle(input string tag);
        bit done;
        bit pend;
        done = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            step();
            pend = 0;
            for (int k = 0; k < NUM_CH; k++) if (src_cnt[k] > 0) pend = 1;
            if (!pend && !busy_o) done = 1;
        end
        repeat (3) step();
        check_val({tag, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        for (int k = 0; k < NUM_CH; k++) src_cnt[k] = 0;
        rst = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    function automatic int q_at(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        int exp_ch;
        rst = 1'b1; kill = 1'b0; kill_arm = 0; stat_sel_i = '0;
        req_val_i = '0; req_real_i = '0; req_imag_i = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            src_cnt[k] = 0; pay_re[k] = '0; pay_im[k] = '0;
        end
        repeat (6) @(posedge clk);
        #1;
        check_val("rst_rdy", 32'(req_rdy_o), 32'd0);
        check_val("rst_abs_val", 32'(abs_val_o), 32'd0);
        check_val("rst_abs_real", 32'(abs_real_o), 32'd0);
        check_val("rst_abs_imag", 32'(abs_imag_o), 32'd0);
        check_val("rst_res_val", 32'(res_val_o), 32'd0);
        check_val("rst_res_abs", 32'(res_abs_o), 32'd0);
        check_val("rst_res_ch", 32'(res_ch_o), 32'd0);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_err", 32'(err_o), 32'd0);
        check_val("rst_stat", 32'(stat_cnt_o), 32'd0);
        rst = 1'b0;
        clear_logs();

        // Single channel: ch2 sends five 3+4j samples.
        pay_re[2] = 8'h03; pay_im[2] = 8'h04; src_cnt[2] = 5;
        drive();
        run_until_idle("single");
        check_val("single_runs", 32'(run_ch.size()), 32'd1);
        check_val("single_run_ch", 32'(q_at(run_ch, 0)), 32'd2);
        check_val("single_xfers", 32'(q_at(run_x, 0)), 32'd5);
        check_val("single_nres", 32'(res_ch.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("single_ch%0d", i), 32'(q_at(res_ch, i)), 32'd2);
            check_val($sformatf("single_abs%0d", i), 32'(q_at(res_abs, i)), 32'd5);
        end
        check_val("single_latency", 32'(res_first - xfer_first), 32'd6);
        check_val("single_err", 32'(err_o), 32'd0);
        check_val("single_onehot", 32'(onehot_bad), 32'd0);

        // Burst limit: ch0 streams 40 samples of 6+8j.
        clear_logs();
        pay_re[0] = 8'd6; pay_im[0] = 8'd8; src_cnt[0] = 40;
        drive();
        run_until_idle("burst");
        check_val("burst_runs", 32'(run_ch.size()), 32'd3);
        check_val("burst_x0", 32'(q_at(run_x, 0)), 32'd16);
        check_val("burst_x1", 32'(q_at(run_x, 1)), 32'd16);
        check_val("burst_x2", 32'(q_at(run_x, 2)), 32'd8);
        check_val("burst_gap1", 32'(q_at(run_gap, 1)), 32'd1);
        check_val("burst_gap2", 32'(q_at(run_gap, 2)), 32'd1);
        check_val("burst_nres", 32'(res_ch.size()), 32'd40);
        bad = 0;
        foreach (res_ch[i]) if (res_ch[i] != 0 || res_abs[i] != 10) bad++;
        check_val("burst_res_bad", 32'(bad), 32'd0);

        // Fairness: everyone requests, ch k sends k+0j.
        do_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            pay_re[k] = DW'(k); pay_im[k] = '0; src_cnt[k] = 32;
        end
        drive();
        run_until_idle("fair");
        check_val("fair_runs", 32'(run_ch.size()), 32'd8);
        bad = 0;
        foreach (run_ch[i]) begin
            if (run_ch[i] != i % 4 || run_x[i] != 16) bad++;
            if (i > 0 && run_gap[i] != 1) bad++;
        end
        check_val("fair_order_bad", 32'(bad), 32'd0);
        check_val("fair_nres", 32'(res_ch.size()), 32'd128);
        bad = 0;
        foreach (res_ch[i]) begin
            exp_ch = (i / 16) % 4;
            if (res_ch[i] != exp_ch || res_abs[i] != exp_ch) bad++;
        end
        check_val("fair_res_bad", 32'(bad), 32'd0);
        check_val("fair_onehot", 32'(onehot_bad), 32'd0);

        // Early release: ch1 quits after 3, ch3 waiting, ch0 arrives mid-burst.
        clear_logs();
        src_cnt[1] = 3; src_cnt[3] = 5;
        drive();
        step(); step();
        src_cnt[0] = 2;
        run_until_idle("early");
        check_val("early_runs", 32'(run_ch.size()), 32'd3);
        check_val("early_ch0", 32'(q_at(run_ch, 0)), 32'd1);
        check_val("early_x0", 32'(q_at(run_x, 0)), 32'd3);
        check_val("early_len0", 32'(q_at(run_len, 0)), 32'd4);
        check_val("early_ch1", 32'(q_at(run_ch, 1)), 32'd3);
        check_val("early_gap1", 32'(q_at(run_gap, 1)), 32'd1);
        check_val("early_x1", 32'(q_at(run_x, 1)), 32'd5);
        check_val("early_ch2", 32'(q_at(run_ch, 2)), 32'd0);
        check_val("early_nres", 32'(res_ch.size()), 32'd10);
        check_val("early_res3", 32'(q_at(res_ch, 3)), 32'd3);

        // Reset after 5 of 10 ch0 transfers.
        clear_logs();
        pay_re[0] = 8'd9; pay_im[0] = 8'd12; src_cnt[0] = 10;
        drive();
        for (int n = 0; n < 100 && xfer_log.size() < 5; n++) step();
        check_val("mrst_reach5", 32'(xfer_log.size()), 32'd5);
        rst = 1'b1;
        #1;
        check_val("mrst_rdy", 32'(req_rdy_o), 32'd0);
        check_val("mrst_abs_val", 32'(abs_val_o), 32'd0);
        check_val("mrst_abs_real", 32'(abs_real_o), 32'd0);
        check_val("mrst_res_val", 32'(res_val_o), 32'd0);
        check_val("mrst_busy", 32'(busy_o), 32'd0);
        for (int k = 0; k < NUM_CH; k++) src_cnt[k] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        pay_re[1] = 8'd5; pay_im[1] = 8'd12; src_cnt[1] = 2;
        pay_re[3] = 8'd8; pay_im[3] = 8'd15; src_cnt[3] = 2;
        drive();
        run_until_idle("mrst");
        check_val("mrst_first_ch", 32'(q_at(run_ch, 0)), 32'd1);
        check_val("mrst_nres", 32'(res_ch.size()), 32'd4);
        check_val("mrst_r0", 32'(q_at(res_abs, 0)), 32'd13);
        check_val("mrst_r3_ch", 32'(q_at(res_ch, 3)), 32'd3);
        check_val("mrst_r3", 32'(q_at(res_abs, 3)), 32'd17);
        check_val("mrst_err", 32'(err_o), 32'd0);

        // Mismatch: one valid tag sees abs_val_i low.
        clear_logs();
        stat_sel_i = 2'd2;
        pay_re[2] = 8'd3; pay_im[2] = 8'd4; src_cnt[2] = 4;
        kill_arm = 1;
        drive();
        run_until_idle("mism");
        check_val("mism_err", 32'(err_o), 32'd1);
        check_val("mism_nres", 32'(res_ch.size()), 32'd3);
        bad = 0;
        foreach (res_ch[i]) if (res_ch[i] != 2 || res_abs[i] != 5) bad++;
        check_val("mism_res_bad", 32'(bad), 32'd0);
`ifdef ABS_ARB_STATS_EN
        check_val("mism_stat", 32'(stat_cnt_o), 32'd3);
`else
        check_val("mism_stat", 32'(stat_cnt_o), 32'd0);
`endif
        clear_logs();
        src_cnt[1] = 1;
        drive();
        run_until_idle("sticky");
        check_val("sticky_err", 32'(err_o), 32'd1);
        check_val("sticky_nres", 32'(res_ch.size()), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
